// File: rtl/id_pkg.sv
// id_pkg: shared constants for the instruction-decode stage.
//   - opcode and R-type / SPECIAL2 funct field values
//   - ALU operation codes (alu_op_e)
//   - MemToReg, HiLoOp, MemWrite, SEMux and ALU source encodings
package id_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // R-type funct values
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MOVN  = 6'h0B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // SPECIAL2 funct values
    localparam logic [5:0] FN2_MADD = 6'h00;
    localparam logic [5:0] FN2_MUL  = 6'h02;
    localparam logic [5:0] FN2_MSUB = 6'h04;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT  = 5'd6,  ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA  = 5'd10, ALU_LUI  = 5'd11,
        ALU_MUL  = 5'd12, ALU_EQ   = 5'd13, ALU_NE   = 5'd14, ALU_PASS = 5'd15
    } alu_op_e;

    // MemToReg
    localparam logic [2:0] M2R_ALU = 3'b000;
    localparam logic [2:0] M2R_LW  = 3'b001;
    localparam logic [2:0] M2R_LH  = 3'b010;
    localparam logic [2:0] M2R_LB  = 3'b011;
    localparam logic [2:0] M2R_PC4 = 3'b100;
    localparam logic [2:0] M2R_HI  = 3'b101;
    localparam logic [2:0] M2R_LO  = 3'b110;

    // HiLoOp
    localparam logic [2:0] HL_NONE  = 3'b000;
    localparam logic [2:0] HL_MULT  = 3'b001;
    localparam logic [2:0] HL_MULTU = 3'b010;
    localparam logic [2:0] HL_MTHI  = 3'b011;
    localparam logic [2:0] HL_MTLO  = 3'b100;
    localparam logic [2:0] HL_MADD  = 3'b101;
    localparam logic [2:0] HL_MSUB  = 3'b110;

    // MemWrite
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SW   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SB   = 2'b11;

    // SEMux
    localparam logic [1:0] SE_SIGN = 2'b00;
    localparam logic [1:0] SE_ZERO = 2'b01;
    localparam logic [1:0] SE_HIGH = 2'b10;

    // ALU operand sources
    localparam logic [1:0] SRCA_RS    = 2'b00;
    localparam logic [1:0] SRCA_SHAMT = 2'b01;
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;

endpackage

// File: rtl/id_stage_v2_register_file.sv
// register_file: 32 x 32-bit general register file.
//   clk, reset          - clock, synchronous active-high clear
//   we, waddr, wdata    - synchronous write port ($0 writes ignored)
//   raddr1/2, rdata1/2  - combinational read ports with same-cycle
//                         write bypass; $0 always reads 0
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (wr_en && raddr1 == waddr) ? wdata : regs_q[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = (wr_en && raddr2 == waddr) ? wdata : regs_q[raddr2];
        end
    end
endmodule

// File: rtl/id_stage_v2.sv
// id_stage_v2: instruction-decode stage of the 5-stage pipeline.
//   Inputs : Clk, Reset, WB write port (cRegWrite, RegWriteAddress,
//            RegWriteData), Instruction, PCPlus4, Hi, Lo.
//   Outputs: oc* EX/MEM/WB control decoded combinationally from
//            Instruction; oReadReg1/2 (rs/rt contents), oSEImm,
//            oI2016/oI1511 register fields, pass-through PC+4/Hi/Lo.
module id_stage_v2
    import id_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cRegWrite,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] Instruction,
    input  logic [31:0] RegWriteData,
    input  logic [4:0]  RegWriteAddress,
    input  logic [31:0] Hi,
    input  logic [31:0] Lo,
    output logic [1:0]  ocALUSrcA,
    output logic [1:0]  ocALUSrcB,
    output logic        ocRegDst,
    output logic [2:0]  ocHiLoOp,
    output logic [4:0]  ocALUCtrl,
    output logic        ocBranch,
    output logic        ocPCMux,
    output logic [1:0]  ocMemWrite,
    output logic        ocMemRead,
    output logic        ocMove,
    output logic        ocRegWriteCtrl,
    output logic [2:0]  ocMemToReg,
    output logic [1:0]  ocSEMux,
    output logic        ocRegAddress,
    output logic [31:0] oPCPlus4,
    output logic [31:0] oReadReg1,
    output logic [31:0] oReadReg2,
    output logic [31:0] oSEImm,
    output logic [4:0]  oI2016,
    output logic [4:0]  oI1511,
    output logic [31:0] oHi,
    output logic [31:0] oLo
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode = Instruction[31:26];
    assign funct  = Instruction[5:0];
    assign imm    = Instruction[15:0];

    assign oPCPlus4 = PCPlus4;
    assign oHi      = Hi;
    assign oLo      = Lo;
    assign oI2016   = Instruction[20:16];
    assign oI1511   = Instruction[15:11];

    register_file u_regfile (
        .clk    (Clk),
        .reset  (Reset),
        .we     (cRegWrite),
        .waddr  (RegWriteAddress),
        .wdata  (RegWriteData),
        .raddr1 (Instruction[25:21]),
        .raddr2 (Instruction[20:16]),
        .rdata1 (oReadReg1),
        .rdata2 (oReadReg2)
    );

    always_comb begin
        case (ocSEMux)
            SE_ZERO: oSEImm = {16'h0000, imm};
            SE_HIGH: oSEImm = {imm, 16'h0000};
            default: oSEImm = {{16{imm[15]}}, imm};
        endcase
    end

    always_comb begin
        ocALUSrcA      = SRCA_RS;
        ocALUSrcB      = SRCB_RT;
        ocRegDst       = 1'b0;
        ocHiLoOp       = HL_NONE;
        ocALUCtrl      = ALU_ADD;
        ocBranch       = 1'b0;
        ocPCMux        = 1'b0;
        ocMemWrite     = MW_NONE;
        ocMemRead      = 1'b0;
        ocMove         = 1'b0;
        ocRegWriteCtrl = 1'b0;
        ocMemToReg     = M2R_ALU;
        ocSEMux        = SE_SIGN;
        ocRegAddress   = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                ocRegDst       = 1'b1;
                ocRegWriteCtrl = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ocALUCtrl = ALU_ADD;
                    FN_SUB, FN_SUBU: ocALUCtrl = ALU_SUB;
                    FN_AND:  ocALUCtrl = ALU_AND;
                    FN_OR:   ocALUCtrl = ALU_OR;
                    FN_XOR:  ocALUCtrl = ALU_XOR;
                    FN_NOR:  ocALUCtrl = ALU_NOR;
                    FN_SLT:  ocALUCtrl = ALU_SLT;
                    FN_SLTU: ocALUCtrl = ALU_SLTU;
                    FN_SLL: begin ocALUSrcA = SRCA_SHAMT; ocALUCtrl = ALU_SLL; end
                    FN_SRL: begin ocALUSrcA = SRCA_SHAMT; ocALUCtrl = ALU_SRL; end
                    FN_SRA: begin ocALUSrcA = SRCA_SHAMT; ocALUCtrl = ALU_SRA; end
                    FN_MULT:  begin ocHiLoOp = HL_MULT;  ocRegWriteCtrl = 1'b0; end
                    FN_MULTU: begin ocHiLoOp = HL_MULTU; ocRegWriteCtrl = 1'b0; end
                    FN_MFHI: ocMemToReg = M2R_HI;
                    FN_MFLO: ocMemToReg = M2R_LO;
                    FN_MTHI: begin ocHiLoOp = HL_MTHI; ocRegWriteCtrl = 1'b0; end
                    FN_MTLO: begin ocHiLoOp = HL_MTLO; ocRegWriteCtrl = 1'b0; end
                    FN_MOVN, FN_MOVZ: begin ocMove = 1'b1; ocALUCtrl = ALU_PASS; end
                    FN_JR: begin ocPCMux = 1'b1; ocRegWriteCtrl = 1'b0; end
                    default: ;
                endcase
            end
            OP_SPECIAL2: begin
                case (funct)
                    FN2_MADD: ocHiLoOp = HL_MADD;
                    FN2_MSUB: ocHiLoOp = HL_MSUB;
                    FN2_MUL: begin
                        ocRegDst       = 1'b1;
                        ocRegWriteCtrl = 1'b1;
                        ocALUCtrl      = ALU_MUL;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ocALUSrcB      = SRCB_IMM;
                ocRegWriteCtrl = 1'b1;
                case (opcode)
                    OP_SLTI:  ocALUCtrl = ALU_SLT;
                    OP_SLTIU: ocALUCtrl = ALU_SLTU;
                    OP_ANDI: begin ocALUCtrl = ALU_AND; ocSEMux = SE_ZERO; end
                    OP_ORI:  begin ocALUCtrl = ALU_OR;  ocSEMux = SE_ZERO; end
                    OP_XORI: begin ocALUCtrl = ALU_XOR; ocSEMux = SE_ZERO; end
                    OP_LUI:  begin ocALUCtrl = ALU_LUI; ocSEMux = SE_HIGH; end
                    default: ocALUCtrl = ALU_ADD;
                endcase
            end
            OP_LW, OP_LH, OP_LB: begin
                ocALUSrcB      = SRCB_IMM;
                ocMemRead      = 1'b1;
                ocRegWriteCtrl = 1'b1;
                case (opcode)
                    OP_LW:   ocMemToReg = M2R_LW;
                    OP_LH:   ocMemToReg = M2R_LH;
                    default: ocMemToReg = M2R_LB;
                endcase
            end
            OP_SW: begin ocALUSrcB = SRCB_IMM; ocMemWrite = MW_SW; end
            OP_SH: begin ocALUSrcB = SRCB_IMM; ocMemWrite = MW_SH; end
            OP_SB: begin ocALUSrcB = SRCB_IMM; ocMemWrite = MW_SB; end
            OP_BEQ: begin ocBranch = 1'b1; ocALUCtrl = ALU_EQ; end
            OP_BNE: begin ocBranch = 1'b1; ocALUCtrl = ALU_NE; end
            OP_J:   ocPCMux = 1'b1;
            OP_JAL: begin
                ocPCMux        = 1'b1;
                ocRegAddress   = 1'b1;
                ocMemToReg     = M2R_PC4;
                ocRegWriteCtrl = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_id_stage_v2.sv
// tb_id_stage_v2: directed self-checking bench for id_stage_v2.
module tb_id_stage_v2;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        cRegWrite;
    logic [31:0] PCPlus4, Instruction, RegWriteData, Hi, Lo;
    logic [4:0]  RegWriteAddress;
    logic [1:0]  ocALUSrcA, ocALUSrcB, ocMemWrite, ocSEMux;
    logic        ocRegDst, ocBranch, ocPCMux, ocMemRead, ocMove, ocRegWriteCtrl, ocRegAddress;
    logic [2:0]  ocHiLoOp, ocMemToReg;
    logic [4:0]  ocALUCtrl, oI2016, oI1511;
    logic [31:0] oPCPlus4, oReadReg1, oReadReg2, oSEImm, oHi, oLo;

    int checks = 0;
    int failures = 0;

    // Control bundle, MSB first:
    // SrcA(2) SrcB(2) RegDst HiLoOp(3) ALUCtrl(5) Branch PCMux MemWrite(2)
    // MemRead Move RegWriteCtrl MemToReg(3) SEMux(2) RegAddress
    logic [25:0] ctrl;
    assign ctrl = {ocALUSrcA, ocALUSrcB, ocRegDst, ocHiLoOp, ocALUCtrl, ocBranch, ocPCMux,
                   ocMemWrite, ocMemRead, ocMove, ocRegWriteCtrl, ocMemToReg, ocSEMux, ocRegAddress};

    always #5 Clk = ~Clk;

    id_stage_v2 dut (
        .Clk(Clk), .Reset(Reset), .cRegWrite(cRegWrite), .PCPlus4(PCPlus4),
        .Instruction(Instruction), .RegWriteData(RegWriteData),
        .RegWriteAddress(RegWriteAddress), .Hi(Hi), .Lo(Lo),
        .ocALUSrcA(ocALUSrcA), .ocALUSrcB(ocALUSrcB), .ocRegDst(ocRegDst),
        .ocHiLoOp(ocHiLoOp), .ocALUCtrl(ocALUCtrl), .ocBranch(ocBranch),
        .ocPCMux(ocPCMux), .ocMemWrite(ocMemWrite), .ocMemRead(ocMemRead),
        .ocMove(ocMove), .ocRegWriteCtrl(ocRegWriteCtrl), .ocMemToReg(ocMemToReg),
        .ocSEMux(ocSEMux), .ocRegAddress(ocRegAddress), .oPCPlus4(oPCPlus4),
        .oReadReg1(oReadReg1), .oReadReg2(oReadReg2), .oSEImm(oSEImm),
        .oI2016(oI2016), .oI1511(oI1511), .oHi(oHi), .oLo(oLo)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; cRegWrite = 1'b0; RegWriteAddress = '0; RegWriteData = '0;
        Instruction = 32'h0; PCPlus4 = '0; Hi = '0; Lo = '0;
        tick(); tick();
        Reset = 1'b0;
        Instruction = {6'h00, 5'd9, 5'd10, 16'h0000};
        #1;
        checks++;
        if (oReadReg1 !== 32'd0) begin failures++; $display("FAIL reset_rs got=%h exp=%h", oReadReg1, 32'd0); end
        checks++;
        if (oReadReg2 !== 32'd0) begin failures++; $display("FAIL reset_rt got=%h exp=%h", oReadReg2, 32'd0); end
    endtask

    task automatic test_decode_add();
        Instruction = 32'h01284020;
        #1;
        checks++;
        if (ctrl !== {2'b00, 2'b00, 1'b1, 3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0}) begin
            failures++; $display("FAIL add_ctrl got=%h exp=%h", ctrl,
                {2'b00, 2'b00, 1'b1, 3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0});
        end
        checks++;
        if (oI2016 !== 5'd8 || oI1511 !== 5'd8) begin failures++; $display("FAIL add_fields got=%0d/%0d exp=8/8", oI2016, oI1511); end
        checks++;
        if (oReadReg1 !== 32'd0) begin failures++; $display("FAIL add_rs got=%h exp=0", oReadReg1); end
        checks++;
        if (oSEImm !== 32'h00004020) begin failures++; $display("FAIL add_imm got=%h exp=%h", oSEImm, 32'h00004020); end
    endtask

    task automatic test_decode_lw();
        Instruction = 32'h8D284030;
        #1;
        checks++;
        if (ctrl !== {2'b00, 2'b01, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b001, 2'b00, 1'b0}) begin
            failures++; $display("FAIL lw_ctrl got=%h exp=%h", ctrl,
                {2'b00, 2'b01, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b001, 2'b00, 1'b0});
        end
        checks++;
        if (oSEImm !== 32'h00004030 || oI2016 !== 5'd8) begin
            failures++; $display("FAIL lw_imm got=%h/%0d exp=00004030/8", oSEImm, oI2016);
        end
    endtask

    task automatic test_other_decodes();
        logic [25:0] exp_c [6];
        logic [31:0] instr [6];
        instr[0] = 32'hAD280004; // sw
        exp_c[0] = {2'b00, 2'b01, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};
        instr[1] = 32'h11280003; // beq
        exp_c[1] = {2'b00, 2'b00, 1'b0, 3'b000, 5'd13, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};
        instr[2] = 32'h0C000010; // jal
        exp_c[2] = {2'b00, 2'b00, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'b100, 2'b00, 1'b1};
        instr[3] = 32'hFC000000; // unknown opcode
        exp_c[3] = '0;
        instr[4] = 32'h00084080; // sll $8,$8,2
        exp_c[4] = {2'b01, 2'b00, 1'b1, 3'b000, 5'd8, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0};
        instr[5] = 32'h00004010; // mfhi $8
        exp_c[5] = {2'b00, 2'b00, 1'b1, 3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b101, 2'b00, 1'b0};
        for (int i = 0; i < 6; i++) begin
            Instruction = instr[i];
            #1;
            checks++;
            if (ctrl !== exp_c[i]) begin
                failures++; $display("FAIL decode_%h got=%h exp=%h", instr[i], ctrl, exp_c[i]);
            end
        end
    endtask

    task automatic test_write_read();
        cRegWrite = 1'b1; RegWriteAddress = 5'd7; RegWriteData = 32'd22;
        tick();
        cRegWrite = 1'b0; RegWriteData = 32'd0;
        Instruction = {6'h00, 5'd7, 5'd7, 16'h0000};
        #1;
        checks++;
        if (oReadReg1 !== 32'd22) begin failures++; $display("FAIL write_read_rs got=%0d exp=22", oReadReg1); end
        checks++;
        if (oReadReg2 !== 32'd22) begin failures++; $display("FAIL write_read_rt got=%0d exp=22", oReadReg2); end
    endtask

    task automatic test_bypass();
        cRegWrite = 1'b1; RegWriteAddress = 5'd7; RegWriteData = 32'd22;
        Instruction = {6'h00, 5'd7, 5'd0, 16'h0000};
        #1;
        checks++;
        if (oReadReg1 !== 32'd22) begin failures++; $display("FAIL bypass_same got=%0d exp=22", oReadReg1); end
        // Unwritten register: only the bypass can produce the value
        RegWriteAddress = 5'd13; RegWriteData = 32'h12345678;
        Instruction = {6'h00, 5'd13, 5'd13, 16'h0000};
        #1;
        checks++;
        if (oReadReg1 !== 32'h12345678) begin failures++; $display("FAIL bypass_rs got=%h exp=12345678", oReadReg1); end
        checks++;
        if (oReadReg2 !== 32'h12345678) begin failures++; $display("FAIL bypass_rt got=%h exp=12345678", oReadReg2); end
        cRegWrite = 1'b0;
        #1;
        checks++;
        if (oReadReg1 !== 32'd0) begin failures++; $display("FAIL bypass_off got=%h exp=0", oReadReg1); end
        tick();
    endtask

    task automatic test_zero_reg();
        cRegWrite = 1'b1; RegWriteAddress = 5'd0; RegWriteData = 32'd99;
        Instruction = {6'h00, 5'd0, 5'd0, 16'h0000};
        #1;
        checks++;
        if (oReadReg1 !== 32'd0) begin failures++; $display("FAIL zero_bypass got=%0d exp=0", oReadReg1); end
        tick();
        cRegWrite = 1'b0;
        #1;
        checks++;
        if (oReadReg1 !== 32'd0 || oReadReg2 !== 32'd0) begin
            failures++; $display("FAIL zero_reg got=%0d/%0d exp=0/0", oReadReg1, oReadReg2);
        end
    endtask

    task automatic test_passthrough();
        PCPlus4 = 32'd11; Hi = 32'd33; Lo = 32'd44;
        #1;
        checks++;
        if (oPCPlus4 !== 32'd11) begin failures++; $display("FAIL pc4 got=%0d exp=11", oPCPlus4); end
        checks++;
        if (oHi !== 32'd33 || oLo !== 32'd44) begin failures++; $display("FAIL hilo got=%0d/%0d exp=33/44", oHi, oLo); end
    endtask

    task automatic test_extend();
        Instruction = 32'h2001FFF0; // addi $1,$0,-16
        #1;
        checks++;
        if (oSEImm !== 32'hFFFFFFF0) begin failures++; $display("FAIL addi_imm got=%h exp=FFFFFFF0", oSEImm); end
        checks++;
        if (ctrl !== {2'b00, 2'b01, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0}) begin
            failures++; $display("FAIL addi_ctrl got=%h", ctrl);
        end
        Instruction = 32'h3401FFF0; // ori $1,$0,0xFFF0
        #1;
        checks++;
        if (oSEImm !== 32'h0000FFF0) begin failures++; $display("FAIL ori_imm got=%h exp=0000FFF0", oSEImm); end
        checks++;
        if (ctrl !== {2'b00, 2'b01, 1'b0, 3'b000, 5'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 1'b0}) begin
            failures++; $display("FAIL ori_ctrl got=%h", ctrl);
        end
        Instruction = 32'h3C011234; // lui $1,0x1234
        #1;
        checks++;
        if (oSEImm !== 32'h12340000 || ocALUCtrl !== 5'd11) begin
            failures++; $display("FAIL lui got=%h/%0d exp=12340000/11", oSEImm, ocALUCtrl);
        end
    endtask

    task automatic test_reset_priority();
        // $7 holds 22; a simultaneous write must lose to reset
        Reset = 1'b1; cRegWrite = 1'b1; RegWriteAddress = 5'd7; RegWriteData = 32'd5;
        tick();
        Reset = 1'b0; cRegWrite = 1'b0;
        Instruction = {6'h00, 5'd7, 5'd7, 16'h0000};
        #1;
        checks++;
        if (oReadReg1 !== 32'd0 || oReadReg2 !== 32'd0) begin
            failures++; $display("FAIL reset_priority got=%0d/%0d exp=0/0", oReadReg1, oReadReg2);
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_decode_add();
        test_decode_lw();
        test_other_decodes();
        @(negedge Clk);
        test_write_read();
        @(negedge Clk);
        test_bypass();
        @(negedge Clk);
        test_zero_reg();
        test_passthrough();
        test_extend();
        @(negedge Clk);
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
